// File: rtl/text_ram_arbiter.sv
// Arbitrates the single text-RAM port between the editor (read/write) and the display fetcher (read).
// Optional TEXT_ARB_STATS_EN adds editor stall statistics (stall_cnt, max_wait).
module text_ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int LINE_W     = 2560,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ed_req,
  input  logic              ed_we,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [LINE_W-1:0] ed_wdata,
  output logic              ed_gnt,
  output logic              ed_rvalid,
  output logic [LINE_W-1:0] ed_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [LINE_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata,
  output logic              busy
`ifdef TEXT_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [7:0]        max_wait
`endif
);

  typedef enum logic [1:0] {ARB, WRITE, READ_WAIT, RETURN} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [2:0] LAT0 = 3'(RD_LAT - 1);

  state_t     state;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner_ed;
  logic       rv_pend;
  logic       disp_win;
  logic       ed_win;

  always_comb begin
    disp_win = disp_req && ((starve_cnt < SMAX) || !ed_req);
    ed_win   = ed_req && !disp_win;
  end

  // rdata registers are deliberately not reset: they are only meaningful with rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_ed    <= 1'b0;
      rv_pend     <= 1'b0;
      ed_gnt      <= 1'b0;
      disp_gnt    <= 1'b0;
      ed_rvalid   <= 1'b0;
      disp_rvalid <= 1'b0;
      ram_addr    <= '0;
      ram_wren    <= 1'b0;
      ram_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      ed_gnt      <= 1'b0;
      disp_gnt    <= 1'b0;
      rv_pend     <= 1'b0;
      ed_rvalid   <= rv_pend && owner_ed;
      disp_rvalid <= rv_pend && !owner_ed;
      case (state)
        ARB: begin
          ram_wren <= 1'b0;
          if (disp_win) begin
            disp_gnt <= 1'b1;
            ram_addr <= disp_addr;
            owner_ed <= 1'b0;
            lat_cnt  <= LAT0;
            busy     <= 1'b1;
            state    <= READ_WAIT;
            if (!ed_req)
              starve_cnt <= '0;
            else if (starve_cnt != SMAX)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (ed_win) begin
            ed_gnt     <= 1'b1;
            ram_addr   <= ed_addr;
            starve_cnt <= '0;
            busy       <= 1'b1;
            if (ed_we) begin
              ram_wren  <= 1'b1;
              ram_wdata <= ed_wdata;
              state     <= WRITE;
            end else begin
              owner_ed <= 1'b1;
              lat_cnt  <= LAT0;
              state    <= READ_WAIT;
            end
          end
        end
        WRITE: begin
          ram_wren <= 1'b0;
          busy     <= 1'b0;
          state    <= ARB;
        end
        READ_WAIT: begin
          if (lat_cnt == 3'd0)
            state <= RETURN;
          else
            lat_cnt <= lat_cnt - 3'd1;
        end
        RETURN: begin
          // capture now, announce one cycle later to keep rdata and rvalid aligned
          if (owner_ed)
            ed_rdata <= ram_rdata;
          else
            disp_rdata <= ram_rdata;
          rv_pend <= 1'b1;
          busy    <= 1'b0;
          state   <= ARB;
        end
        default: begin
          busy  <= 1'b0;
          state <= ARB;
        end
      endcase
    end
  end

`ifdef TEXT_ARB_STATS_EN
  logic       ed_take;
  logic [7:0] wait_cur;

  assign ed_take = (state == ARB) && ed_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      max_wait  <= '0;
      wait_cur  <= '0;
    end else if (ed_req && !ed_take) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (wait_cur != 8'hFF)     wait_cur  <= wait_cur + 8'd1;
    end else if (ed_take) begin
      if (wait_cur > max_wait) max_wait <= wait_cur;
      wait_cur <= '0;
    end else begin
      wait_cur <= '0;
    end
  end
`endif

endmodule
